// File: rtl/data_pack_pkg.sv
// Shared definitions for the data packer FIFO: width helpers and reset values.
package data_pack_pkg;

  // Width of one packed output word.
  function automatic int out_width(input int in_w, input int ratio);
    return in_w * ratio;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  // Beat counter width, never narrower than one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  localparam logic RST_EMPTY = 1'b1;
  localparam logic RST_FULL  = 1'b0;
  localparam logic RST_FLAG  = 1'b0;

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO with wrap-bit pointers, registered status flags and a
// registered read port. Status flags are derived from the next-state
// pointers so they always agree with level in the same cycle.
module sync_fifo_core import data_pack_pkg::*; #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int AF_LEVEL   = 56
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int PW    = ptr_width(DEPTH_LOG2);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n, level_n;
  logic          do_write, do_read;

  // A write into a full FIFO is only accepted when a read frees a slot the same cycle.
  always_comb begin
    do_read  = rd_en && !empty;
    do_write = wr_en && (!full || do_read);
    wptr_n   = do_write ? (wptr + PTR_ONE) : wptr;
    rptr_n   = do_read  ? (rptr + PTR_ONE) : rptr;
    level_n  = wptr_n - rptr_n;
  end

  // Storage array write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Pointers, flags, level and the registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      empty       <= RST_EMPTY;
      full        <= RST_FULL;
      almost_full <= RST_FLAG;
      rd_data     <= '0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      level       <= level_n;
      empty       <= (wptr_n == rptr_n);
      full        <= (wptr_n[PW-2:0] == rptr_n[PW-2:0]) && (wptr_n[PW-1] != rptr_n[PW-1]);
      almost_full <= (level_n >= AF_THR);
      if (do_read) begin
        rd_data <= mem[rptr[DEPTH_LOG2-1:0]];
      end
    end
  end

endmodule

// File: rtl/data_pack_fifo.sv
// Packs RATIO narrow beats (LSB first) into one wide word and buffers the
// words in sync_fifo_core. Adds sticky overflow/underflow flags.
// Optional macro DATA_PACK_FLUSH_EN adds a flush input that writes a
// zero-padded partial word.
module data_pack_fifo import data_pack_pkg::*; #(
  parameter int IN_W       = 8,
  parameter int RATIO      = 2,
  parameter int DEPTH_LOG2 = 6,
  parameter int AF_LEVEL   = 56,
  localparam int OUT_W     = out_width(IN_W, RATIO)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [IN_W-1:0]      data_in,
  input  logic                 read_en,
`ifdef DATA_PACK_FLUSH_EN
  input  logic                 flush,
`endif
  output logic [OUT_W-1:0]     data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CW = cnt_width(RATIO);
  localparam logic [CW-1:0] LAST    = CW'(RATIO - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] hold, assembled, word;
  logic             beat, word_done, flush_write, wr_req;

  // Merge the current beat into the holding register and decide whether a word is complete.
  always_comb begin
    assembled = hold;
    assembled[cnt*IN_W +: IN_W] = data_in;
    beat      = in_valid && !start;
    word_done = beat && (cnt == LAST);
`ifdef DATA_PACK_FLUSH_EN
    flush_write = flush && !start && !word_done && (beat || (cnt != '0));
    word        = beat ? assembled : hold;
`else
    flush_write = 1'b0;
    word        = assembled;
`endif
    wr_req = word_done || flush_write;
  end

  // Beat counter and holding register; cleared after every emitted word so padding is zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      hold <= '0;
    end else if (start || wr_req) begin
      cnt  <= '0;
      hold <= '0;
    end else if (beat) begin
      cnt  <= cnt + CNT_ONE;
      hold <= assembled;
    end
  end

  // Sticky error flags; start clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= RST_FLAG;
      underflow <= RST_FLAG;
    end else if (start) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && full && !read_en) begin
        overflow <= 1'b1;
      end
      if (read_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  sync_fifo_core #(
    .W          (OUT_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .AF_LEVEL   (AF_LEVEL)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_req),
    .wr_data     (word),
    .rd_en       (read_en),
    .rd_data     (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level)
  );

endmodule

// File: tb/tb_data_pack_fifo.sv
// Scoreboard bench for data_pack_fifo (IN_W=8, RATIO=2, depth 64).
// Covers flush behaviour when DATA_PACK_FLUSH_EN is defined.
module tb_data_pack_fifo;

  localparam int IN_W       = 8;
  localparam int RATIO      = 2;
  localparam int DEPTH_LOG2 = 6;
  localparam int AF_LEVEL   = 56;
  localparam int OUT_W      = 16;
  localparam int DEPTH      = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              in_valid;
  logic [IN_W-1:0]   data_in;
  logic              read_en;
`ifdef DATA_PACK_FLUSH_EN
  logic              flush;
`endif
  logic [OUT_W-1:0]  data_out;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [DEPTH_LOG2:0] level;
  logic              overflow;
  logic              underflow;

  int errors = 0;
  int checks = 0;
  logic [OUT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  data_pack_fifo #(
    .IN_W       (IN_W),
    .RATIO      (RATIO),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .AF_LEVEL   (AF_LEVEL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .read_en     (read_en),
`ifdef DATA_PACK_FLUSH_EN
    .flush       (flush),
`endif
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d, input logic rd, input logic st);
    in_valid = v;
    data_in  = d;
    read_en  = rd;
    start    = st;
    tick();
    in_valid = 1'b0;
    data_in  = '0;
    read_en  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic sendWord(input logic [OUT_W-1:0] w);
    applyStimulus(1'b1, w[7:0], 1'b0, 1'b0);
    applyStimulus(1'b1, w[15:8], 1'b0, 1'b0);
  endtask

  // Monitor: any accepted pop must present the oldest expected word after the edge.
  initial begin
    logic pop;
    logic [OUT_W-1:0] e;
    forever begin
      @(negedge clk);
      pop = reset_n && read_en && !empty;
      @(posedge clk);
      #2;
      if (pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL pop_unexpected: got 0x%0h expected no pop", data_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_data_out", 32'(data_out), 32'(e));
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    read_en  = 1'b0;
`ifdef DATA_PACK_FLUSH_EN
    flush    = 1'b0;
`endif
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_af", 32'(almost_full), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);

    // Two beats form 0x1234, then pop it
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
    checkOutput("half_empty", 32'(empty), 32'd1);
    checkOutput("half_level", 32'(level), 32'd0);
    exp_q.push_back(16'h1234);
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    checkOutput("word_empty", 32'(empty), 32'd0);
    checkOutput("word_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop_level", 32'(level), 32'd0);
    checkOutput("pop_empty", 32'(empty), 32'd1);
    checkOutput("pop_data", 32'(data_out), 32'h1234);

    // Fill to 64 words, tracking almost_full and full
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(16'(16'hA000 + i));
      sendWord(16'(16'hA000 + i));
      checkOutput("fill_level", 32'(level), 32'(i + 1));
      checkOutput("fill_af", 32'(almost_full), 32'((i + 1) >= AF_LEVEL));
      checkOutput("fill_full", 32'(full), 32'((i + 1) == DEPTH));
    end

    // One more word while full is dropped
    sendWord(16'hEEFF);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_level", 32'(level), 32'd64);
    checkOutput("ovf_full", 32'(full), 32'd1);

    // Clear flags, then complete a word while popping on a full FIFO
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("start_clr_ovf", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    exp_q.push_back(16'h0201);
    applyStimulus(1'b1, 8'h02, 1'b1, 1'b0);
    checkOutput("wr_rd_full_level", 32'(level), 32'd64);
    checkOutput("wr_rd_full_ovf", 32'(overflow), 32'd0);
    checkOutput("wr_rd_full_full", 32'(full), 32'd1);
    checkOutput("wr_rd_full_data", 32'(data_out), 32'hA000);

    // Drain everything in order
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_last", 32'(data_out), 32'h0201);

    // Read while empty
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_flag", 32'(underflow), 32'd1);
    checkOutput("udf_data_hold", 32'(data_out), 32'h0201);
    checkOutput("udf_level", 32'(level), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("start_clr_udf", 32'(underflow), 32'd0);

    // start discards the partial word and its own beat
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
    checkOutput("start_level", 32'(level), 32'd0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("start_half_level", 32'(level), 32'd0);
    exp_q.push_back(16'h2211);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    checkOutput("start_word_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("start_word_data", 32'(data_out), 32'h2211);

`ifdef DATA_PACK_FLUSH_EN
    // Flush pads a partial word; flush with no beats does nothing
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    exp_q.push_back(16'h0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_level", 32'(level), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_idle_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush_data", 32'(data_out), 32'h0001);
    exp_q.push_back(16'h0005);
    flush    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'h05;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    checkOutput("flush_beat_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush_beat_data", 32'(data_out), 32'h0005);
`endif

    // Reset in the middle of a word loses everything
    exp_q.push_back(16'h5544);
    sendWord(16'h5544);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    checkOutput("midrst_level", 32'(level), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_data", 32'(data_out), 32'd0);
    exp_q.push_back(16'h8877);
    sendWord(16'h8877);
    checkOutput("postrst_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("postrst_data", 32'(data_out), 32'h8877);

    tick();
    tick();
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
